// File: rtl/ext_mem_loader_pkg.sv
// Shared definitions for the external memory loader: FSM state encoding,
// memory strides and a small width helper.
package ext_mem_loader_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOAD      = 3'd1;
    localparam state_t ST_RUN       = 3'd2;
    localparam state_t ST_DUMP_RD   = 3'd3;
    localparam state_t ST_DUMP_WAIT = 3'd4;
    localparam state_t ST_DUMP_OUT  = 3'd5;
    localparam state_t ST_DONE      = 3'd6;

    // Byte strides between consecutive words of each memory
    localparam logic [63:0] IMEM_STRIDE = 64'd4;
    localparam logic [63:0] DMEM_STRIDE = 64'd8;

    // Larger of two widths, used to size the shared index counter
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/ext_mem_loader_counter.sv
// loader_counter: loadable (clear-to-zero) up-counter with a terminal-count
// flag that is high while the count equals the supplied terminal value.
module loader_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority over increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {W{1'b0}};
        end else if (inc_i) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/ext_mem_loader.sv
// ext_mem_loader: streams a program image into instruction memory, runs the
// CPU for a programmed number of cycles, then streams data memory back out.
// Zero-length phases are skipped outright.
module ext_mem_loader
    import ext_mem_loader_pkg::*;
#(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   start,
    input  logic [IMEM_ADDR_W:0]   imem_len,
    input  logic [31:0]            run_cycles,
    input  logic [DMEM_ADDR_W:0]   dump_len,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [31:0]            s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [63:0]            m_data,
    output logic                   busy,
    output logic                   done,
    output logic                   cpu_enable,
    output logic [63:0]            addr_ext,
    output logic                   wen_ext,
    output logic                   ren_ext,
    output logic [31:0]            wdata_ext,
    output logic [63:0]            addr_ext_2,
    output logic                   wen_ext_2,
    output logic                   ren_ext_2,
    output logic [63:0]            wdata_ext_2,
    input  logic [63:0]            rdata_ext_2
);

    // One spare bit so the index can step past the last word without wrapping
    localparam int IDX_W = max_int(IMEM_ADDR_W, DMEM_ADDR_W) + 1;

    state_t                 state_q,      state_d;
    logic [IMEM_ADDR_W:0]   imem_len_q,   imem_len_d;
    logic [31:0]            run_cycles_q, run_cycles_d;
    logic [DMEM_ADDR_W:0]   dump_len_q,   dump_len_d;
    logic [63:0]            m_data_q,     m_data_d;

    logic [IDX_W-1:0]       idx_cnt_s;
    logic [IDX_W-1:0]       idx_term_s;
    logic                   idx_tc_s;
    logic                   idx_clr_s;
    logic                   idx_inc_s;
    logic [31:0]            run_cnt_unused_s;
    logic [31:0]            run_term_s;
    logic                   run_tc_s;
    logic                   run_clr_s;
    logic                   run_inc_s;

    // First non-empty phase among load, run and dump
    function automatic state_t first_phase(input logic has_load,
                                           input logic has_run,
                                           input logic has_dump);
        if (has_load) begin
            return ST_LOAD;
        end else if (has_run) begin
            return ST_RUN;
        end else if (has_dump) begin
            return ST_DUMP_RD;
        end else begin
            return ST_DONE;
        end
    endfunction

    // Index of the final word in the current load or dump phase
    always_comb begin
        idx_term_s = {IDX_W{1'b0}};
        if (state_q == ST_LOAD) begin
            idx_term_s = IDX_W'(imem_len_q) - {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            idx_term_s = IDX_W'(dump_len_q) - {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    assign run_term_s = run_cycles_q - 32'd1;

    // Sequencer next-state, length capture and dump data capture
    always_comb begin
        state_d      = state_q;
        imem_len_d   = imem_len_q;
        run_cycles_d = run_cycles_q;
        dump_len_d   = dump_len_q;
        m_data_d     = m_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    imem_len_d   = imem_len;
                    run_cycles_d = run_cycles;
                    dump_len_d   = dump_len;
                    state_d      = first_phase(|imem_len, |run_cycles, |dump_len);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (s_valid && idx_tc_s) begin
                    state_d = first_phase(1'b0, |run_cycles_q, |dump_len_q);
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (run_tc_s) begin
                    state_d = first_phase(1'b0, 1'b0, |dump_len_q);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DUMP_RD: begin
                state_d = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                // Read data arrives one cycle after the read enable
                m_data_d = rdata_ext_2;
                state_d  = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (m_ready) begin
                    if (idx_tc_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DUMP_RD;
                    end
                end else begin
                    state_d = ST_DUMP_OUT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter controls: the index restarts at zero for each load/dump phase
    always_comb begin
        idx_clr_s = (state_q == ST_IDLE) ||
                    ((state_q == ST_LOAD) && (state_d != ST_LOAD));
        idx_inc_s = ((state_q == ST_LOAD) && s_valid) ||
                    ((state_q == ST_DUMP_OUT) && m_ready);
        run_clr_s = (state_q != ST_RUN);
        run_inc_s = (state_q == ST_RUN);
    end

    loader_counter #(.W(IDX_W)) u_idx_cnt (
        .clk     (clk),
        .srst    (srst),
        .clr_i   (idx_clr_s),
        .inc_i   (idx_inc_s),
        .term_i  (idx_term_s),
        .count_o (idx_cnt_s),
        .tc_o    (idx_tc_s)
    );

    loader_counter #(.W(32)) u_run_cnt (
        .clk     (clk),
        .srst    (srst),
        .clr_i   (run_clr_s),
        .inc_i   (run_inc_s),
        .term_i  (run_term_s),
        .count_o (run_cnt_unused_s),
        .tc_o    (run_tc_s)
    );

    // State, captured lengths and dump data register with synchronous reset
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            imem_len_q   <= {(IMEM_ADDR_W+1){1'b0}};
            run_cycles_q <= 32'd0;
            dump_len_q   <= {(DMEM_ADDR_W+1){1'b0}};
            m_data_q     <= 64'd0;
        end else begin
            state_q      <= state_d;
            imem_len_q   <= imem_len_d;
            run_cycles_q <= run_cycles_d;
            dump_len_q   <= dump_len_d;
            m_data_q     <= m_data_d;
        end
    end

    // Port decode: load writes are combinational with the stream handshake
    always_comb begin
        s_ready     = 1'b0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = 32'd0;
        addr_ext    = 64'd0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = 64'd0;
        addr_ext_2  = 64'd0;
        m_valid     = (state_q == ST_DUMP_OUT);
        m_data      = m_data_q;
        cpu_enable  = (state_q == ST_RUN);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        if (state_q == ST_LOAD) begin
            s_ready  = 1'b1;
            wen_ext  = s_valid;
            addr_ext = 64'(idx_cnt_s) * IMEM_STRIDE;
            if (s_valid) begin
                wdata_ext = s_data;
            end else begin
                wdata_ext = 32'd0;
            end
        end else if (state_q == ST_DUMP_RD) begin
            ren_ext_2  = 1'b1;
            addr_ext_2 = 64'(idx_cnt_s) * DMEM_STRIDE;
        end else begin
            s_ready = 1'b0;
        end
    end

endmodule
